id_ex_stage: RTL and testbench

ID/EX pipeline register with integrated load-use hazard detection for the 5-stage RISC-V core. It captures decoded operands and control from ID, and drives the `id_ex_*` source/destination addresses and control consumed by `forwarding_unit` and the EX stage. It inserts a single bubble on a load-use dependency, honours downstream stalls and branch flushes, and keeps a saturating count of load-use stall cycles.

---
 rtl/riscv_pkg.sv | 44 ++++
 rtl/id_ex_stage_load_use_detector.sv | 28 ++
 rtl/id_ex_stage.sv | 177 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the 5-stage RISC-V core pipeline registers and
// forwarding logic.
package riscv_pkg;

   // Forwarding mux selects driven by forwarding_unit.
   typedef enum logic [1:0] {
      NO_FWD  = 2'b00,
      FWD_EX  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_e;

   // ALU operation encodings (4-bit ALU op field).
   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLL  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_SLT  = 4'd8;
   localparam logic [3:0] ALU_SLTU = 4'd9;

   // The hard-wired zero register; never a forwarding or hazard source.
   localparam logic [4:0] REG_X0 = 5'd0;

   // Single-bit control bundle carried from ID/EX into EX/MEM.
   typedef struct packed {
      logic write_enable;
      logic mem_read;
      logic mem_write;
      logic alu_src;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '0;

   // True when an instruction that really reads `src` names register `dest`.
   function automatic logic reads_reg(input logic       uses,
                                      input logic [4:0] src,
                                      input logic [4:0] dest);
      return uses & (src == dest);
   endfunction

endpackage

// File: rtl/id_ex_stage_load_use_detector.sv
// Combinational load-use hazard detection: the instruction in ID reads the
// destination of a load that currently sits in ID/EX.
module load_use_detector
   import riscv_pkg::*;
(
   input  logic       if_id_valid_i,
   input  logic       id_ex_valid_i,
   input  logic       id_ex_mem_read_i,
   input  logic [4:0] id_ex_dest_addr_i,
   input  logic       id_uses_rs1_i,
   input  logic [4:0] id_src1_addr_i,
   input  logic       id_uses_rs2_i,
   input  logic [4:0] id_src2_addr_i,
   output logic       lu_o
);

   logic load_in_ex;
   logic src_hit;

   // A load to x0 produces nothing to wait for, so it never stalls.
   assign load_in_ex = id_ex_valid_i & id_ex_mem_read_i & (id_ex_dest_addr_i != REG_X0);

   assign src_hit = reads_reg(id_uses_rs1_i, id_src1_addr_i, id_ex_dest_addr_i)
                  | reads_reg(id_uses_rs2_i, id_src2_addr_i, id_ex_dest_addr_i);

   assign lu_o = if_id_valid_i & load_in_ex & src_hit;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, downstream hold,
// branch flush and a saturating count of load-use bubbles.
module id_ex_stage
   import riscv_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int ALU_OP_W = 4,
   parameter int CNT_W    = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_id_valid,
   input  logic [XLEN-1:0]     id_pc,
   input  logic [XLEN-1:0]     id_rs1_data,
   input  logic [XLEN-1:0]     id_rs2_data,
   input  logic [XLEN-1:0]     id_imm,
   input  logic [4:0]          id_src1_addr,
   input  logic [4:0]          id_src2_addr,
   input  logic [4:0]          id_dest_addr,
   input  logic                id_uses_rs1,
   input  logic                id_uses_rs2,
   input  logic                id_write_enable,
   input  logic                id_mem_read,
   input  logic                id_mem_write,
   input  logic                id_alu_src,
   input  logic [ALU_OP_W-1:0] id_alu_op,
   input  logic                ex_stall,
   input  logic                flush,
   output logic                id_ex_valid,
   output logic [XLEN-1:0]     id_ex_pc,
   output logic [XLEN-1:0]     id_ex_rs1_data,
   output logic [XLEN-1:0]     id_ex_rs2_data,
   output logic [XLEN-1:0]     id_ex_imm,
   output logic [4:0]          id_ex_src1_addr,
   output logic [4:0]          id_ex_src2_addr,
   output logic [4:0]          id_ex_dest_addr,
   output logic                id_ex_write_enable,
   output logic                id_ex_mem_read,
   output logic                id_ex_mem_write,
   output logic                id_ex_alu_src,
   output logic [ALU_OP_W-1:0] id_ex_alu_op,
   output logic                stall_if_id,
   output logic [CNT_W-1:0]    load_use_count
);

   logic                lu;
   logic                load_bubble;
   logic                load_id;
   logic                count_inc;
   ctrl_t               id_ctrl;

   logic                valid_q,  valid_d;
   logic [XLEN-1:0]     pc_q,     pc_d;
   logic [XLEN-1:0]     rs1_q,    rs1_d;
   logic [XLEN-1:0]     rs2_q,    rs2_d;
   logic [XLEN-1:0]     imm_q,    imm_d;
   logic [4:0]          src1_q,   src1_d;
   logic [4:0]          src2_q,   src2_d;
   logic [4:0]          dest_q,   dest_d;
   ctrl_t               ctrl_q,   ctrl_d;
   logic [ALU_OP_W-1:0] alu_op_q, alu_op_d;
   logic [CNT_W-1:0]    count_q,  count_d;

   assign id_ctrl = '{write_enable: id_write_enable,
                      mem_read:     id_mem_read,
                      mem_write:    id_mem_write,
                      alu_src:      id_alu_src};

   load_use_detector u_load_use_detector (
      .if_id_valid_i     (if_id_valid),
      .id_ex_valid_i     (valid_q),
      .id_ex_mem_read_i  (ctrl_q.mem_read),
      .id_ex_dest_addr_i (dest_q),
      .id_uses_rs1_i     (id_uses_rs1),
      .id_src1_addr_i    (id_src1_addr),
      .id_uses_rs2_i     (id_uses_rs2),
      .id_src2_addr_i    (id_src2_addr),
      .lu_o              (lu)
   );

   // Priority: flush > downstream hold > load-use bubble > load from ID.
   // An invalid ID slot is written as a bubble so no stale fields leak out.
   assign load_bubble = flush | (~ex_stall & (lu | ~if_id_valid));
   assign load_id     = ~flush & ~ex_stall & ~lu & if_id_valid;
   assign count_inc   = lu & ~ex_stall & ~flush;
   assign stall_if_id = ~flush & (ex_stall | lu);

   // Next-state select for the pipeline register (hold by default).
   always_comb begin
      valid_d  = valid_q;
      pc_d     = pc_q;
      rs1_d    = rs1_q;
      rs2_d    = rs2_q;
      imm_d    = imm_q;
      src1_d   = src1_q;
      src2_d   = src2_q;
      dest_d   = dest_q;
      ctrl_d   = ctrl_q;
      alu_op_d = alu_op_q;
      if (load_bubble) begin
         valid_d  = 1'b0;
         pc_d     = '0;
         rs1_d    = '0;
         rs2_d    = '0;
         imm_d    = '0;
         src1_d   = REG_X0;
         src2_d   = REG_X0;
         dest_d   = REG_X0;
         ctrl_d   = CTRL_NOP;
         alu_op_d = '0;
      end else if (load_id) begin
         valid_d  = 1'b1;
         pc_d     = id_pc;
         rs1_d    = id_rs1_data;
         rs2_d    = id_rs2_data;
         imm_d    = id_imm;
         src1_d   = id_src1_addr;
         src2_d   = id_src2_addr;
         dest_d   = id_dest_addr;
         ctrl_d   = id_ctrl;
         alu_op_d = id_alu_op;
      end
   end

   // Saturating bubble counter; sticks at all-ones instead of wrapping.
   always_comb begin
      count_d = count_q;
      if (count_inc && (count_q != {CNT_W{1'b1}})) begin
         count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q  <= 1'b0;
         pc_q     <= '0;
         rs1_q    <= '0;
         rs2_q    <= '0;
         imm_q    <= '0;
         src1_q   <= REG_X0;
         src2_q   <= REG_X0;
         dest_q   <= REG_X0;
         ctrl_q   <= CTRL_NOP;
         alu_op_q <= '0;
         count_q  <= '0;
      end else begin
         valid_q  <= valid_d;
         pc_q     <= pc_d;
         rs1_q    <= rs1_d;
         rs2_q    <= rs2_d;
         imm_q    <= imm_d;
         src1_q   <= src1_d;
         src2_q   <= src2_d;
         dest_q   <= dest_d;
         ctrl_q   <= ctrl_d;
         alu_op_q <= alu_op_d;
         count_q  <= count_d;
      end
   end

   assign id_ex_valid        = valid_q;
   assign id_ex_pc           = pc_q;
   assign id_ex_rs1_data     = rs1_q;
   assign id_ex_rs2_data     = rs2_q;
   assign id_ex_imm          = imm_q;
   assign id_ex_src1_addr    = src1_q;
   assign id_ex_src2_addr    = src2_q;
   assign id_ex_dest_addr    = dest_q;
   assign id_ex_write_enable = ctrl_q.write_enable;
   assign id_ex_mem_read     = ctrl_q.mem_read;
   assign id_ex_mem_write    = ctrl_q.mem_write;
   assign id_ex_alu_src      = ctrl_q.alu_src;
   assign id_ex_alu_op       = alu_op_q;
   assign load_use_count     = count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: the driver applies one ID word per cycle
// and pushes the expected response; a monitor pops and compares.
module tb_id_ex_stage;

   localparam int CW      = 5;
   localparam int CNT_MAX = (1 << CW) - 1;

   typedef struct packed {
      logic        v;
      logic [31:0] pc, rs1, rs2, imm;
      logic [4:0]  s1, s2, d;
      logic        u1, u2, we, mr, mw, as;
      logic [3:0]  op;
   } id_t;

   typedef struct packed {
      logic        v;
      logic [31:0] pc, rs1, rs2, imm;
      logic [4:0]  s1, s2, d;
      logic        we, mr, mw, as;
      logic [3:0]  op;
   } st_t;

   typedef struct {
      bit  stall;
      st_t st;
      int  cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_id_valid = 0;
   logic [31:0] id_pc = 0, id_rs1_data = 0, id_rs2_data = 0, id_imm = 0;
   logic [4:0]  id_src1_addr = 0, id_src2_addr = 0, id_dest_addr = 0;
   logic        id_uses_rs1 = 0, id_uses_rs2 = 0;
   logic        id_write_enable = 0, id_mem_read = 0, id_mem_write = 0, id_alu_src = 0;
   logic [3:0]  id_alu_op = 0;
   logic        ex_stall = 0, flush = 0;

   logic        id_ex_valid;
   logic [31:0] id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm;
   logic [4:0]  id_ex_src1_addr, id_ex_src2_addr, id_ex_dest_addr;
   logic        id_ex_write_enable, id_ex_mem_read, id_ex_mem_write, id_ex_alu_src;
   logic [3:0]  id_ex_alu_op;
   logic        stall_if_id;
   logic [CW-1:0] load_use_count;

   int   checks = 0;
   int   failures = 0;
   bit   mon_en = 0;
   int   txn = 0;
   exp_t q[$];
   st_t  m;          // reference contents of the ID/EX slot
   int   cnt_m;      // reference bubble count

   id_ex_stage #(.XLEN(32), .ALU_OP_W(4), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .if_id_valid(if_id_valid),
      .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_src1_addr(id_src1_addr), .id_src2_addr(id_src2_addr), .id_dest_addr(id_dest_addr),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .id_write_enable(id_write_enable), .id_mem_read(id_mem_read),
      .id_mem_write(id_mem_write), .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
      .ex_stall(ex_stall), .flush(flush),
      .id_ex_valid(id_ex_valid), .id_ex_pc(id_ex_pc), .id_ex_rs1_data(id_ex_rs1_data),
      .id_ex_rs2_data(id_ex_rs2_data), .id_ex_imm(id_ex_imm),
      .id_ex_src1_addr(id_ex_src1_addr), .id_ex_src2_addr(id_ex_src2_addr),
      .id_ex_dest_addr(id_ex_dest_addr), .id_ex_write_enable(id_ex_write_enable),
      .id_ex_mem_read(id_ex_mem_read), .id_ex_mem_write(id_ex_mem_write),
      .id_ex_alu_src(id_ex_alu_src), .id_ex_alu_op(id_ex_alu_op),
      .stall_if_id(stall_if_id), .load_use_count(load_use_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   function automatic id_t mk_id(input logic [31:0] pc, input logic [4:0] s1, input logic [4:0] s2,
                                 input logic [4:0] d, input logic u1, input logic u2,
                                 input logic we, input logic mr);
      id_t r;
      r = '{v: 1'b1, pc: pc, rs1: pc + 32'h11, rs2: pc + 32'h22, imm: pc + 32'h33,
            s1: s1, s2: s2, d: d, u1: u1, u2: u2, we: we, mr: mr, mw: 1'b0, as: 1'b0,
            op: 4'd3};
      return r;
   endfunction

   function automatic id_t rnd_id();
      id_t r;
      r.v   = ($urandom_range(0, 9) != 0);
      r.pc  = $urandom; r.rs1 = $urandom; r.rs2 = $urandom; r.imm = $urandom;
      r.s1  = 5'($urandom_range(0, 3));
      r.s2  = 5'($urandom_range(0, 3));
      r.d   = 5'($urandom_range(0, 3));
      r.u1  = 1'($urandom); r.u2 = 1'($urandom);
      r.we  = 1'($urandom); r.mr = 1'($urandom);
      r.mw  = 1'($urandom); r.as = 1'($urandom);
      r.op  = 4'($urandom);
      return r;
   endfunction

   // Apply one ID word for one cycle and record what the stage must do.
   task automatic drive(input id_t id, input bit st, input bit fl);
      exp_t e;
      bit   hazard;
      @(negedge clk);
      if_id_valid = id.v; id_pc = id.pc; id_rs1_data = id.rs1; id_rs2_data = id.rs2;
      id_imm = id.imm; id_src1_addr = id.s1; id_src2_addr = id.s2; id_dest_addr = id.d;
      id_uses_rs1 = id.u1; id_uses_rs2 = id.u2; id_write_enable = id.we;
      id_mem_read = id.mr; id_mem_write = id.mw; id_alu_src = id.as; id_alu_op = id.op;
      ex_stall = st; flush = fl;
      hazard = id.v && m.v && m.mr && (m.d != 0) &&
               ((id.u1 && id.s1 == m.d) || (id.u2 && id.s2 == m.d));
      e.stall = !fl && (st || hazard);
      if (fl)               m = '0;
      else if (st)          m = m;
      else if (hazard)      m = '0;
      else if (!id.v)       m = '0;
      else m = '{v: 1'b1, pc: id.pc, rs1: id.rs1, rs2: id.rs2, imm: id.imm,
                 s1: id.s1, s2: id.s2, d: id.d, we: id.we, mr: id.mr, mw: id.mw,
                 as: id.as, op: id.op};
      if (hazard && !st && !fl && cnt_m < CNT_MAX) cnt_m++;
      e.st  = m;
      e.cnt = cnt_m;
      q.push_back(e);
   endtask

   // Monitor: combinational stall before the edge, registered state after it.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (mon_en && q.size() > 0) chk("stall_if_id", 32'(stall_if_id), 32'(q[0].stall));
         @(posedge clk);
         #1;
         if (mon_en && q.size() > 0) begin
            e = q.pop_front();
            txn++;
            chk("valid", 32'(id_ex_valid), 32'(e.st.v));
            chk("pc",    id_ex_pc,       e.st.pc);
            chk("rs1",   id_ex_rs1_data, e.st.rs1);
            chk("rs2",   id_ex_rs2_data, e.st.rs2);
            chk("imm",   id_ex_imm,      e.st.imm);
            chk("addrs", {17'd0, id_ex_src1_addr, id_ex_src2_addr, id_ex_dest_addr},
                         {17'd0, e.st.s1, e.st.s2, e.st.d});
            chk("ctrl",  {24'd0, id_ex_write_enable, id_ex_mem_read, id_ex_mem_write,
                          id_ex_alu_src, id_ex_alu_op},
                         {24'd0, e.st.we, e.st.mr, e.st.mw, e.st.as, e.st.op});
            chk("count", 32'(load_use_count), 32'(e.cnt));
            $display("txn %0d valid=%0b pc=%h dest=%0d mr=%0b stall=%0b count=%0d",
                     txn, id_ex_valid, id_ex_pc, id_ex_dest_addr, id_ex_mem_read,
                     e.stall, load_use_count);
         end
      end
   end

   task automatic drain();
      for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
      #3;
      chk("drain", 32'(q.size()), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_valid"}, 32'(id_ex_valid), 32'd0);
      chk({tag, "_data"},  id_ex_pc | id_ex_rs1_data | id_ex_rs2_data | id_ex_imm, 32'd0);
      chk({tag, "_addrs"}, {17'd0, id_ex_src1_addr, id_ex_src2_addr, id_ex_dest_addr}, 32'd0);
      chk({tag, "_ctrl"},  {24'd0, id_ex_write_enable, id_ex_mem_read, id_ex_mem_write,
                            id_ex_alu_src, id_ex_alu_op}, 32'd0);
      chk({tag, "_count"}, 32'(load_use_count), 32'd0);
   endtask

   initial begin
      id_t lw5, add5, itype, lw0, rd0, nxt;
      m = '0;
      cnt_m = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check_all_zero("reset");
      chk("reset_stall", 32'(stall_if_id), 32'd0);
      mon_en = 1;

      // Plain pass-through.
      drive(mk_id(32'h100, 5'd1, 5'd2, 5'd3, 1, 1, 1, 0), 0, 0);
      drive('0, 0, 0);

      // Load-use: lw x5 then add x6,x5,x1 -> one bubble, then the add enters.
      lw5  = mk_id(32'h200, 5'd2, 5'd0, 5'd5, 1, 0, 1, 1);
      add5 = mk_id(32'h204, 5'd5, 5'd1, 5'd6, 1, 1, 1, 0);
      drive(lw5, 0, 0);
      drive(add5, 0, 0);
      drive(add5, 0, 0);

      // No false stall: unused rs2 match, and a load to x0.
      itype = mk_id(32'h300, 5'd7, 5'd5, 5'd8, 1, 0, 1, 0);
      lw0   = mk_id(32'h304, 5'd2, 5'd0, 5'd0, 1, 0, 1, 1);
      rd0   = mk_id(32'h308, 5'd0, 5'd0, 5'd9, 1, 1, 1, 0);
      drive(lw5, 0, 0);
      drive(itype, 0, 0);
      drive(lw0, 0, 0);
      drive(rd0, 0, 0);

      // Downstream hold for 3 cycles with a new word waiting, then release.
      nxt = mk_id(32'h400, 5'd3, 5'd4, 5'd10, 1, 1, 1, 0);
      for (int i = 0; i < 3; i++) drive(nxt, 1, 0);
      drive(nxt, 0, 0);

      // Flush together with load-use and hold.
      drive(lw5, 0, 0);
      drive(add5, 1, 1);
      drive(add5, 0, 0);

      // Randomized traffic.
      for (int i = 0; i < 1200; i++)
         drive(rnd_id(), ($urandom_range(0, 6) == 0), ($urandom_range(0, 11) == 0));

      // Enough back-to-back hazards to push the counter into saturation.
      for (int i = 0; i < CNT_MAX + 8; i++) begin
         drive(lw5, 0, 0);
         drive(add5, 0, 0);
      end
      drive(lw5, 0, 0);
      drain();
      chk("count_saturated", 32'(load_use_count), CNT_MAX);

      // Asynchronous reset between clock edges clears everything at once.
      mon_en = 0;
      @(negedge clk);
      if_id_valid = 0; ex_stall = 0; flush = 0;
      #2;
      rst = 1'b1;
      #1;
      check_all_zero("async_rst");
      chk("async_rst_stall", 32'(stall_if_id), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global time bound so the bench always ends.
   initial begin
      #2000000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
